// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared ALU: accepts one operation from either
// requester, pulses the ALU enable, waits ALU_LAT cycles and returns the result.
module alu_arbiter #(
  parameter int WIDTH   = 18,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [1:0]       alu_select,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             grant_id
);

  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          sel_valid;
  logic          sel;
  logic          wait_last;

  // Tie goes to the port that was not served last.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) sel = ~last_grant;
    else                          sel = req1_valid;
  end

  // Ready is gated by reset so it stays low while reset is held even though
  // the state register already reads IDLE.
  assign req0_ready = reset && (state == ST_IDLE) && sel_valid && !sel;
  assign req1_ready = reset && (state == ST_IDLE) && sel_valid &&  sel;
  assign alu_enable = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign wait_last  = (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (sel_valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (wait_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_select   <= '0;
      rsp_data     <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            alu_operand1 <= sel ? req1_a  : req0_a;
            alu_operand2 <= sel ? req1_b  : req0_b;
            alu_select   <= sel ? req1_op : req0_op;
            grant_id     <= sel;
            last_grant   <= sel;
          end
        end
        ST_ISSUE: cnt <= CW'(ALU_LAT);
        ST_WAIT: begin
          cnt <= cnt - CW'(1);
          if (wait_last) begin
            rsp_data <= alu_result;
            if (grant_id) rsp1_valid <= 1'b1;
            else          rsp0_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each driving a behavioural ALU that only presents its result after the latency.
module tb_alu_arbiter;

  localparam int W = 18;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;
  localparam logic [W-1:0] JUNK  = 18'h15A5A;

  typedef struct {
    logic         port;
    logic [W-1:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic v0[2], v1[2], rdy0[2], rdy1[2], r0v[2], r1v[2], en[2], busy[2], gid[2];
  logic [1:0]   op0[2], op1[2], sel[2];
  logic [W-1:0] a0[2], b0[2], a1[2], b1[2], rd[2], o1[2], o2[2], res[2];
  int   k[2] = '{0, 0};
  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;

  alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .rsp0_valid(r0v[0]), .rsp1_valid(r1v[0]), .rsp_data(rd[0]),
    .alu_operand1(o1[0]), .alu_operand2(o2[0]), .alu_select(sel[0]),
    .alu_enable(en[0]), .alu_result(res[0]), .busy(busy[0]), .grant_id(gid[0])
  );

  alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .rsp0_valid(r0v[1]), .rsp1_valid(r1v[1]), .rsp_data(rd[1]),
    .alu_operand1(o1[1]), .alu_operand2(o2[1]), .alu_select(sel[1]),
    .alu_enable(en[1]), .alu_result(res[1]), .busy(busy[1]), .grant_id(gid[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // The ALU shows garbage until ALU_LAT-1 edges after the enable edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d]) begin
        if (lat_of(d) == 1) res[d] <= alu_f(o1[d], o2[d], sel[d]);
        else begin
          res[d] <= JUNK;
          k[d]   <= lat_of(d) - 1;
        end
      end else if (k[d] != 0) begin
        k[d] <= k[d] - 1;
        if (k[d] == 1) res[d] <= alu_f(o1[d], o2[d], sel[d]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic port, input logic [W-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic mon(input int d);
    exp_t e;
    if ((d == 0 ? qa.size() : qb.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected dut%0d: got {rsp1,rsp0}=%b%b, required no response (t=%0t)",
               d, r1v[d], r0v[d], $time);
    end else begin
      if (d == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      chk("rsp_port", 64'({r1v[d], r0v[d]}), e.port ? 64'd2 : 64'd1);
      chk("rsp_data", 64'(rd[d]), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (r0v[d] || r1v[d]) mon(d);
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
  task automatic op(input int d, input logic port, input logic [1:0] o,
                    input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    push(d, port, exp);
    if (port) begin
      v1[d] = 1'b1; op1[d] = o; a1[d] = a; b1[d] = b;
    end else begin
      v0[d] = 1'b1; op0[d] = o; a0[d] = a; b0[d] = b;
    end
    #1;
    chk("accept_ready", 64'({rdy1[d], rdy0[d]}), port ? 64'd2 : 64'd1);
    @(negedge clk);
    v0[d] = 1'b0;
    v1[d] = 1'b0;
    for (int c = 1; c <= lat_of(d) + 1; c++) begin
      chk("enable_pulse", 64'(en[d]), 64'(c == 1));
      chk("busy_high", 64'(busy[d]), 64'd1);
      if (c == 1) chk("grant_id", 64'(gid[d]), 64'(port));
      @(negedge clk);
    end
    chk("rsp_timing", 64'({r1v[d], r0v[d]}), port ? 64'd2 : 64'd1);
    chk("busy_low_at_rsp", 64'(busy[d]), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v0[d] = 1'b0; v1[d] = 1'b0; op0[d] = '0; op1[d] = '0;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    v0[0] = 1'b1; op0[0] = OP_ADD; a0[0] = 18'h3FFFF; b0[0] = 18'h00001;
    v1[0] = 1'b1; op1[0] = OP_AND; a1[0] = 18'h3FFFF; b1[0] = 18'h0F0F0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs_l1", 64'({rdy0[0], rdy1[0], r0v[0], r1v[0], en[0], busy[0], gid[0],
                                 sel[0], rd[0], o1[0], o2[0]}), 64'd0);
    chk("reset_outputs_l3", 64'({rdy0[1], rdy1[1], r0v[1], r1v[1], en[1], busy[1], gid[1],
                                 sel[1], rd[1], o1[1], o2[1]}), 64'd0);

    // Both requesters valid from reset release: grants alternate 0,1,0,1.
    push(0, 1'b0, 18'h00000);
    push(0, 1'b1, 18'h0F0F0);
    push(0, 1'b0, 18'h00000);
    push(0, 1'b1, 18'h0F0F0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      #1;
      chk("rr_ready0", 64'(rdy0[0]), 64'(c == 0 || c == 6));
      chk("rr_ready1", 64'(rdy1[0]), 64'(c == 3 || c == 9));
      if (c % 3 == 1) chk("rr_grant", 64'(gid[0]), 64'((c / 3) % 2));
      if (c % 3 == 0 && c > 0)
        chk("rr_rsp_cycle", 64'({r1v[0], r0v[0]}), ((c / 3) % 2 == 1) ? 64'd1 : 64'd2);
      if (c == 10) begin
        v0[0] = 1'b0;
        v1[0] = 1'b0;
      end
      @(negedge clk);
    end

    op(0, 1'b0, OP_ADD,  18'h000CC, 18'h000AA, 18'h00176);
    op(0, 1'b1, OP_AND,  18'h000CC, 18'h000AA, 18'h00088);
    op(0, 1'b1, OP_NAND, 18'h000CC, 18'h000AA, 18'h3FF77);
    op(0, 1'b1, OP_NOR,  18'h000CC, 18'h000AA, 18'h3FF11);
    chk("grant_id_held", 64'(gid[0]), 64'd1);

    op(1, 1'b0, OP_ADD, 18'h3FFFF, 18'h00002, 18'h00001);

    // req0 pulses while busy on a port-1 operation and drops before IDLE.
    fork
      op(1, 1'b1, OP_AND, 18'h12345, 18'h0FFFF, 18'h02345);
      begin
        repeat (2) @(negedge clk);
        v0[1] = 1'b1; op0[1] = OP_ADD; a0[1] = 18'h00007; b0[1] = 18'h00007;
        #1;
        chk("busy_ignores_req0", 64'(rdy0[1]), 64'd0);
        @(negedge clk);
        v0[1] = 1'b0;
      end
    join
    v1[1] = 1'b1; op1[1] = OP_AND; a1[1] = 18'h00003; b1[1] = 18'h00001;
    op(1, 1'b0, OP_NOR, 18'h00000, 18'h00000, 18'h3FFFF);

    // Reset asserted in the middle of WAIT aborts the operation.
    v1[1] = 1'b1; op1[1] = OP_ADD; a1[1] = 18'h00005; b1[1] = 18'h00005;
    @(negedge clk);
    v1[1] = 1'b0;
    @(negedge clk);
    v0[1] = 1'b1;
    v1[1] = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy[1]), 64'd0);
    chk("abort_enable", 64'(en[1]), 64'd0);
    chk("abort_ready", 64'({rdy1[1], rdy0[1]}), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_rsp_data", 64'(rd[1]), 64'd0);
    reset = 1'b1;
    op(1, 1'b0, OP_ADD, 18'h00100, 18'h00011, 18'h00111);

    repeat (4) @(negedge clk);
    chk("scoreboard_l1_drained", 64'(qa.size()), 64'd0);
    chk("scoreboard_l3_drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 18-bit ALU between two requesters (e.g. instruction datapath and address/branch unit) with round-robin arbitration.
- Sequences each operation: accept, issue `enable` to the ALU, wait the ALU latency, capture the result, return it to the winner.
- Sits between the requesters and the ALU instance. It is the only driver of the ALU operand, select and enable inputs.

Parameters:
- WIDTH, 18, datapath width of operands and result.
- ALU_LAT, 1, cycles from the ALU `enable` edge to a valid `alu_result`. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accept
- req0_op  in  2  ALU select: 00 ADD, 01 AND, 10 NAND, 11 NOR
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as port 0, for requester 1
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp1_valid  out  1  one-cycle pulse: result for requester 1
- rsp_data  out  WIDTH  captured result; held until the next capture
- alu_operand1  out  WIDTH  to ALU operand1
- alu_operand2  out  WIDTH  to ALU operand2
- alu_select  out  2  to ALU alu_select
- alu_enable  out  1  to ALU enable
- alu_result  in  WIDTH  from ALU result
- busy  out  1  high whenever state != IDLE
- grant_id  out  1  port of the operation in flight or last served

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, including both req_ready, both rsp_valid, alu_enable, rsp_data, alu_operand1/2, alu_select, busy and grant_id.
  - Internal last_grant=1, so port 0 wins the first tie.
- Reset mid-operation: the operation is aborted immediately. No rsp pulse is produced, alu_enable drops asynchronously, and the request is lost (the requester re-issues).
- FSM states IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, ready rules:
  - `reqX_ready` is combinational: (state==IDLE) && sel==X.
  - sel: if exactly one valid, that port. If both valid, the port != last_grant. If neither, no ready.
- IDLE, handshake: a handshake on `valid && ready` at edge T does all of the following:
  - registers a/b/op into alu_operand1/alu_operand2/alu_select;
  - sets grant_id=last_grant=sel;
  - moves to ISSUE.
- ISSUE (cycle T+1): alu_enable=1 for exactly this cycle, with operands stable. Next state is WAIT and the latency counter loads ALU_LAT.
- WAIT (cycles T+2 .. T+1+ALU_LAT):
  - counter decrements each cycle; alu_enable=0.
  - In the last WAIT cycle: rsp_data <= alu_result, rsp{grant_id}_valid <= 1, next state IDLE.
- Response timing: rsp valid is high for exactly one cycle, T+2+ALU_LAT, which is also an IDLE cycle. A new handshake in that same cycle is legal.
- Throughput: one operation per ALU_LAT+2 cycles when back-to-back.
- Operand holding: alu_operand1/2 and alu_select hold their values from accept until the next accept; they are not cleared on completion.
- Arithmetic: the block passes operands through untouched. ADD wraps modulo 2^WIDTH with no carry out, and NAND/NOR are full-width.
- Requesters:
  - Must hold payload stable while valid && !ready.
  - May deassert valid before the handshake; this has no side effect and does not change last_grant.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1.
- A requester's valid during a non-IDLE state is ignored until IDLE. No queueing beyond the requester's own hold.

Test Plan:
- Reset, then req0 only: ADD a=0x000CC, b=0x000AA with ALU_LAT=1. Required: req0_ready in cycle 0, alu_enable in cycle 1 only, rsp0_valid in cycle 3, rsp_data=0x00176, rsp1_valid stays 0.
- req1 only, op=01 (AND), same operands -> rsp1_valid pulse, rsp_data=0x00088, grant_id=1. Then NAND -> 0x3FF77, then NOR -> 0x3FF11.
- Both valid continuously from reset, port0 ADD 0x3FFFF+0x00001, port1 AND 0x3FFFF&0x0F0F0:
  - grant order 0,1,0,1;
  - results 0x00000 (wrap) and 0x0F0F0;
  - each rsp pulse is exactly one cycle on the correct port;
  - new accepts land in the same cycle as the prior rsp.
- ALU_LAT=3 build -> alu_enable is a single-cycle pulse, and rsp_valid arrives exactly 5 cycles after the handshake cycle. busy is high for 4 cycles.
- Assert reset=0 during WAIT -> busy, alu_enable and req_ready go 0 immediately, and no rsp pulse appears afterwards. After release, a fresh req0 completes normally and port 0 wins the first tie.
- req0_valid pulses while busy and drops before IDLE -> never accepted, no rsp0_valid, and last_grant is unchanged.
